// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, instruction field positions, default widths.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package id_pkg;

    // Default widths for the stage parameters
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_IMM_W    = 16;

    // Opcodes the stage cares about
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    // MIPS R/I field bit positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Logical-immediate ops take a zero-extended immediate
    function automatic logic is_logic_imm_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/id_regfile_bypass.sv
// Register file, 2 combinational read ports, 1 write port, reg0 hardwired to zero, write-to-read bypass.
// Latency: reads are same-cycle; writes take effect at the next rising edge (bypassed meanwhile).
// Backpressure: none; writes are always accepted.
module id_regfile_bypass
    import id_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [REG_AW-1:0] rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr_live;

    // A write to reg0 is architecturally a no-op, so it neither updates nor bypasses
    assign wr_live = we_i && (wa_i != '0);

    // Storage update; reg0 is never written so it stays at its reset value of zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_live) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Read port A: reg0 forced to zero, in-flight write-back forwarded ahead of storage
    always_comb begin
        ra_data_o = mem_q[ra_addr_i];
        if (ra_addr_i == '0) begin
            ra_data_o = '0;
        end else if (wr_live && (wa_i == ra_addr_i)) begin
            ra_data_o = wd_i;
        end
    end

    // Read port B: same rules as port A
    always_comb begin
        rb_data_o = mem_q[rb_addr_i];
        if (rb_addr_i == '0) begin
            rb_data_o = '0;
        end else if (wr_live && (wa_i == rb_addr_i)) begin
            rb_data_o = wd_i;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: field decode, register read with WB bypass, load-use hazard, ID/EX register.
// Latency: 1 cycle instr -> idex_*; a load-use hazard inserts exactly one bubble. Optional macro ID_ZEXT_EN
// Backpressure: ex_hold freezes ID/EX and raises stall_out; flush overrides both hold and hazard.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int IMM_W    = DEF_IMM_W,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic              idex_valid,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output logic [DATA_W-1:0] idex_pc4,
    output logic [REG_AW-1:0] idex_rs,
    output logic [REG_AW-1:0] idex_rt,
    output logic [REG_AW-1:0] idex_rd,
    output logic [5:0]        idex_opcode,
    output logic [5:0]        idex_funct
);

    // Decoded fields
    logic [REG_AW-1:0] rs, rt, rd;
    logic [5:0]        opcode, funct;
    logic [DATA_W-1:0] imm_ext, rs_data, rt_data;
    logic              ex_valid_eff, hazard;

    // ID/EX register state and next state
    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [5:0]        opcode_q,  opcode_d;
    logic [5:0]        funct_q,   funct_d;

    // 5-bit register fields are truncated or zero-padded to the register address width
    assign rs     = REG_AW'(instr[RS_MSB:RS_LSB]);
    assign rt     = REG_AW'(instr[RT_MSB:RT_LSB]);
    assign rd     = REG_AW'(instr[RD_MSB:RD_LSB]);
    assign opcode = instr[OP_MSB:OP_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];

`ifdef ID_ZEXT_EN
    // Logical immediates zero-extend, everything else sign-extends
    always_comb begin
        imm_ext = DATA_W'($signed(instr[IMM_W-1:0]));
        if (is_logic_imm_op(opcode)) begin
            imm_ext = DATA_W'(instr[IMM_W-1:0]);
        end
    end
`else
    assign imm_ext = DATA_W'($signed(instr[IMM_W-1:0]));
`endif

    id_regfile_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .ra_addr_i (rs),
        .ra_data_o (rs_data),
        .rb_addr_i (rt),
        .rb_data_o (rt_data),
        .we_i      (wb_en),
        .wa_i      (wb_rd),
        .wd_i      (wb_data)
    );

    // EX contents are meaningless while in reset, so the hazard cannot fire then
    assign ex_valid_eff = ex_valid & reset_n;
    assign hazard       = if_valid & ex_valid_eff & ex_mem_read & (ex_rt != '0)
                        & ((ex_rt == rs) | (ex_rt == rt));
    assign stall_out    = (hazard | ex_hold) & ~flush;

    // ID/EX next state: flush > hold > hazard bubble > normal load
    always_comb begin
        valid_d   = valid_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        pc4_d     = pc4_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        if (flush || (!ex_hold && hazard)) begin
            valid_d   = 1'b0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            pc4_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            opcode_d  = '0;
            funct_d   = '0;
        end else if (!ex_hold) begin
            valid_d   = if_valid;
            rs_data_d = rs_data;
            rt_data_d = rt_data;
            imm_d     = imm_ext;
            pc4_d     = pc4_in;
            rs_d      = rs;
            rt_d      = rt;
            rd_d      = rd;
            opcode_d  = opcode;
            funct_d   = funct;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            opcode_q  <= '0;
            funct_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
        end
    end

    assign idex_valid   = valid_q;
    assign idex_rs_data = rs_data_q;
    assign idex_rt_data = rt_data_q;
    assign idex_imm     = imm_q;
    assign idex_pc4     = pc4_q;
    assign idex_rs      = rs_q;
    assign idex_rt      = rt_q;
    assign idex_rd      = rd_q;
    assign idex_opcode  = opcode_q;
    assign idex_funct   = funct_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, bypass, reg0, load-use hazard, flush, hold, immediate extension.
// Latency: checks registered outputs 1 ns after each rising edge, stall_out 1 ns after input changes.
// Backpressure: exercises ex_hold and flush against the hazard.
module tb_id_stage_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clock;
    logic              reset_n;
    logic              if_valid;
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc4_in;
    logic              ex_hold;
    logic              flush;
    logic              ex_valid;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rt;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              stall_out;
    logic              idex_valid;
    logic [DATA_W-1:0] idex_rs_data, idex_rt_data, idex_imm, idex_pc4;
    logic [REG_AW-1:0] idex_rs, idex_rt, idex_rd;
    logic [5:0]        idex_opcode, idex_funct;

    int total = 0;
    int bad   = 0;

    id_stage_pipe dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .if_valid     (if_valid),
        .instr        (instr),
        .pc4_in       (pc4_in),
        .ex_hold      (ex_hold),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall_out    (stall_out),
        .idex_valid   (idex_valid),
        .idex_rs_data (idex_rs_data),
        .idex_rt_data (idex_rt_data),
        .idex_imm     (idex_imm),
        .idex_pc4     (idex_pc4),
        .idex_rs      (idex_rs),
        .idex_rt      (idex_rt),
        .idex_rd      (idex_rd),
        .idex_opcode  (idex_opcode),
        .idex_funct   (idex_funct)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; pc4_in = 32'h0;
        ex_hold = 1'b1; ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5;
        instr = mk_r(5'd5, 5'd5, 5'd0, 6'h20); if_valid = 1'b1;
        #2;
        total++; if (idex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", idex_valid); end
        total++; if (idex_rs_data !== 32'h0) begin bad++; $display("FAIL rst_rs_data got=%h exp=0", idex_rs_data); end
        total++; if ({idex_imm, idex_pc4} !== 64'h0) begin bad++; $display("FAIL rst_imm_pc4 got=%h exp=0", {idex_imm, idex_pc4}); end
        total++; if ({idex_rs, idex_rt, idex_rd, idex_opcode, idex_funct} !== 27'h0) begin bad++; $display("FAIL rst_fields got=%h exp=0", {idex_rs, idex_rt, idex_rd, idex_opcode, idex_funct}); end
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL rst_stall_hold got=%b exp=1", stall_out); end
        ex_hold = 1'b0;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_stall_nohazard got=%b exp=0", stall_out); end
        tick();
        total++; if (idex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_edge got=%h exp=0", idex_valid); end
        reset_n = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; if_valid = 1'b0; instr = 32'h0;
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        instr = mk_i(6'h08, 5'd3, 5'd0, 16'h0004); pc4_in = 32'h104; if_valid = 1'b1;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL byp_stall got=%b exp=0", stall_out); end
        tick();
        total++; if (idex_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b exp=1", idex_valid); end
        total++; if (idex_rs_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_rs_data got=%h exp=deadbeef", idex_rs_data); end
        total++; if (idex_rt_data !== 32'h0) begin bad++; $display("FAIL byp_rt_data got=%h exp=0", idex_rt_data); end
        total++; if (idex_pc4 !== 32'h104) begin bad++; $display("FAIL byp_pc4 got=%h exp=104", idex_pc4); end
        total++; if (idex_imm !== 32'h4) begin bad++; $display("FAIL byp_imm got=%h exp=4", idex_imm); end
        total++; if (idex_rs !== 5'd3) begin bad++; $display("FAIL byp_rs got=%0d exp=3", idex_rs); end
        wb_rd = 5'd7; wb_data = 32'h1111_2222; instr = mk_r(5'd3, 5'd7, 5'd8, 6'h20);
        tick();
        total++; if (idex_rs_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stored_rs_data got=%h exp=deadbeef", idex_rs_data); end
        total++; if (idex_rt_data !== 32'h1111_2222) begin bad++; $display("FAIL byp_rt_data2 got=%h exp=11112222", idex_rt_data); end
        total++; if (idex_rd !== 5'd8) begin bad++; $display("FAIL byp_rd got=%0d exp=8", idex_rd); end
        wb_en = 1'b0;
        tick();
        total++; if (idex_rt_data !== 32'h1111_2222) begin bad++; $display("FAIL stored_rt_data got=%h exp=11112222", idex_rt_data); end
    endtask

    task automatic test_reg0();
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; instr = mk_r(5'd0, 5'd0, 5'd1, 6'h20);
        tick();
        total++; if (idex_rs_data !== 32'h0) begin bad++; $display("FAIL reg0_bypass got=%h exp=0", idex_rs_data); end
        wb_en = 1'b0;
        tick();
        total++; if (idex_rs_data !== 32'h0) begin bad++; $display("FAIL reg0_stored got=%h exp=0", idex_rs_data); end
        total++; if (idex_rt_data !== 32'h0) begin bad++; $display("FAIL reg0_stored_rt got=%h exp=0", idex_rt_data); end
    endtask

    task automatic test_hazard();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5;
        instr = mk_r(5'd3, 5'd5, 5'd9, 6'h20); pc4_in = 32'h300;
        #1;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL haz_stall got=%b exp=1", stall_out); end
        tick();
        total++; if (idex_valid !== 1'b0) begin bad++; $display("FAIL haz_bubble got=%b exp=0", idex_valid); end
        total++; if (idex_rd !== 5'd0) begin bad++; $display("FAIL haz_bubble_rd got=%0d exp=0", idex_rd); end
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL haz_release_stall got=%b exp=0", stall_out); end
        tick();
        total++; if (idex_valid !== 1'b1) begin bad++; $display("FAIL haz_load_valid got=%b exp=1", idex_valid); end
        total++; if (idex_rt !== 5'd5) begin bad++; $display("FAIL haz_load_rt got=%0d exp=5", idex_rt); end
        total++; if ({idex_rd, idex_funct} !== {5'd9, 6'h20}) begin bad++; $display("FAIL haz_load_rd_funct got=%h exp=%h", {idex_rd, idex_funct}, {5'd9, 6'h20}); end
        total++; if (idex_pc4 !== 32'h300) begin bad++; $display("FAIL haz_load_pc4 got=%h exp=300", idex_pc4); end
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3; instr = mk_r(5'd3, 5'd4, 5'd2, 6'h21);
        #1;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL haz_rs_stall got=%b exp=1", stall_out); end
        ex_rt = 5'd0; instr = mk_r(5'd0, 5'd0, 5'd2, 6'h21);
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL haz_r0_stall got=%b exp=0", stall_out); end
        tick();
        total++; if ({idex_valid, idex_rd} !== {1'b1, 5'd2}) begin bad++; $display("FAIL haz_r0_load got=%h exp=%h", {idex_valid, idex_rd}, {1'b1, 5'd2}); end
        ex_rt = 5'd5; instr = mk_r(5'd5, 5'd5, 5'd2, 6'h21); if_valid = 1'b0;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL haz_noif_stall got=%b exp=0", stall_out); end
        if_valid = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0;
    endtask

    task automatic test_flush();
        tick();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5;
        instr = mk_r(5'd5, 5'd6, 5'd10, 6'h22); flush = 1'b1;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_haz_stall got=%b exp=0", stall_out); end
        tick();
        total++; if (idex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", idex_valid); end
        total++; if (idex_rs !== 5'd0) begin bad++; $display("FAIL flush_rs got=%0d exp=0", idex_rs); end
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_hold = 1'b1;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_hold_stall got=%b exp=0", stall_out); end
        ex_hold = 1'b0; flush = 1'b0;
    endtask

    task automatic test_hold();
        instr = mk_i(6'h08, 5'd3, 5'd4, 16'h0010); pc4_in = 32'h200; if_valid = 1'b1;
        tick();
        total++; if ({idex_valid, idex_imm} !== {1'b1, 32'h10}) begin bad++; $display("FAIL hold_preload got=%h exp=%h", {idex_valid, idex_imm}, {1'b1, 32'h10}); end
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = mk_i(6'h23, 5'(k), 5'(k + 1), 16'(16'h1000 + k)); pc4_in = 32'h400 + k;
            wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'(k);
            #1;
            total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%b exp=1", k, stall_out); end
            tick();
            total++; if ({idex_valid, idex_rs_data, idex_imm, idex_pc4} !== {1'b1, 32'hDEAD_BEEF, 32'h10, 32'h200})
                begin bad++; $display("FAIL hold_data[%0d] got=%h exp=%h", k, {idex_valid, idex_rs_data, idex_imm, idex_pc4}, {1'b1, 32'hDEAD_BEEF, 32'h10, 32'h200}); end
            total++; if ({idex_opcode, idex_rs, idex_rt} !== {6'h08, 5'd3, 5'd4})
                begin bad++; $display("FAIL hold_fields[%0d] got=%h exp=%h", k, {idex_opcode, idex_rs, idex_rt}, {6'h08, 5'd3, 5'd4}); end
        end
        ex_hold = 1'b0; wb_en = 1'b0;
    endtask

    task automatic test_imm();
        logic [31:0] exp_ori, exp_xori;
`ifdef ID_ZEXT_EN
        exp_ori = 32'h0000_8001; exp_xori = 32'h0000_FFFF;
`else
        exp_ori = 32'hFFFF_8001; exp_xori = 32'hFFFF_FFFF;
`endif
        instr = mk_i(6'h0D, 5'd0, 5'd1, 16'h8001);
        tick();
        total++; if (idex_imm !== exp_ori) begin bad++; $display("FAIL imm_ori got=%h exp=%h", idex_imm, exp_ori); end
        instr = mk_i(6'h08, 5'd0, 5'd1, 16'h8001);
        tick();
        total++; if (idex_imm !== 32'hFFFF_8001) begin bad++; $display("FAIL imm_addi got=%h exp=ffff8001", idex_imm); end
        instr = mk_i(6'h0E, 5'd0, 5'd1, 16'hFFFF);
        tick();
        total++; if (idex_imm !== exp_xori) begin bad++; $display("FAIL imm_xori got=%h exp=%h", idex_imm, exp_xori); end
        instr = mk_i(6'h0C, 5'd0, 5'd1, 16'h7FFF);
        tick();
        total++; if (idex_imm !== 32'h0000_7FFF) begin bad++; $display("FAIL imm_andi got=%h exp=00007fff", idex_imm); end
    endtask

    task automatic test_reset_mid_stall();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5;
        instr = mk_r(5'd3, 5'd5, 5'd2, 6'h25); if_valid = 1'b1;
        #1;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL mid_stall_pre got=%b exp=1", stall_out); end
        reset_n = 1'b0;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL mid_stall_rst got=%b exp=0", stall_out); end
        total++; if ({idex_valid, idex_rs_data} !== 33'h0) begin bad++; $display("FAIL mid_rst_out got=%h exp=0", {idex_valid, idex_rs_data}); end
        tick();
        reset_n = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0;
        tick();
        total++; if ({idex_valid, idex_rd, idex_funct} !== {1'b1, 5'd2, 6'h25}) begin bad++; $display("FAIL mid_first_load got=%h exp=%h", {idex_valid, idex_rd, idex_funct}, {1'b1, 5'd2, 6'h25}); end
        total++; if (idex_rs_data !== 32'h0) begin bad++; $display("FAIL mid_regs_cleared got=%h exp=0", idex_rs_data); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_reg0();
        test_hazard();
        test_flush();
        test_hold();
        test_imm();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage for the 5-stage MIPS pipeline, sitting between IF and EX.
- Extracts rs/rt/rd and the immediate from the fetched instruction and reads two operands from an internal register file.
- Write-back data is bypassed into same-cycle reads.
- Detects load-use hazards and handles stall/flush; all results are registered into an ID/EX pipeline register with a valid bit.

Parameters:
DATA_W, 32, register and operand width (>=16)
NUM_REGS, 32, architectural register count (power of two, >=2)
REG_AW, $clog2(NUM_REGS), register address width (derived localparam, not overridable)
IMM_W, 16, immediate field width taken from instr[IMM_W-1:0]

Ports:
clock  in  1  stage clock, rising edge active
reset_n  in  1  asynchronous active-low reset
if_valid  in  1  instr/pc4_in hold a real instruction
instr  in  32  fetched instruction (MIPS R/I format)
pc4_in  in  DATA_W  PC+4 of instr
ex_hold  in  1  EX cannot accept; ID/EX register must hold
flush  in  1  branch/jump taken; kill instruction entering ID/EX
ex_valid  in  1  ID/EX currently holds a valid instruction
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_AW  destination register of that load
wb_en  in  1  write-back enable (EscReg)
wb_rd  in  REG_AW  write-back destination
wb_data  in  DATA_W  write-back value
stall_out  out  1  IF must hold PC and instr this cycle
idex_valid  out  1  ID/EX register valid
idex_rs_data  out  DATA_W  operand A
idex_rt_data  out  DATA_W  operand B
idex_imm  out  DATA_W  extended immediate
idex_pc4  out  DATA_W  PC+4 passed through
idex_rs, idex_rt, idex_rd  out  REG_AW each  register fields
idex_opcode  out  6  instr[31:26]
idex_funct  out  6  instr[5:0]

Behaviour:
- Field decode: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], truncated or zero-padded to REG_AW.
- Register file: NUM_REGS x DATA_W. Writes on rising clock when wb_en=1 and wb_rd!=0. Register 0 always reads 0 and is never written.
- Reads are combinational. Bypass: if wb_en=1, wb_rd!=0 and wb_rd equals the read address, the read returns wb_data in the same cycle.
- Immediate: sign-extend instr[IMM_W-1:0] to DATA_W.
- hazard (combinational) = if_valid & ex_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==rs) | (ex_rt==rt)).
- stall_out = (hazard | ex_hold) & ~flush.
- ID/EX update priority at each rising edge:
  1. flush: idex_valid<=0. Data fields are don't-care; they are zeroed.
  2. ex_hold: all ID/EX outputs hold.
  3. hazard: bubble, idex_valid<=0, data fields zeroed.
  4. Otherwise: load all fields; idex_valid<=if_valid.
- Latency: 1 cycle from instr to idex_* outputs. A hazard inserts exactly one bubble, because the load leaves EX next cycle.
- Reset (async, reset_n=0): every idex_* output 0, all registers 0. stall_out follows its equation with ex_valid forced 0 internally, so it equals ex_hold&~flush. Reset mid-stall drops the bubble; the first instruction after release loads normally.
- Simultaneous write-back and read of the same register: the bypassed value is read and latched.
- Simultaneous flush and hazard: flush wins and stall_out=0.

Optional Feature:
- Macro ID_ZEXT_EN.
- When defined: if opcode is 6'h0C (andi), 6'h0D (ori) or 6'h0E (xori), idex_imm is the zero-extension of instr[IMM_W-1:0]. All other opcodes sign-extend.
- When undefined: always sign-extend; the opcode compare logic is absent.

Decomposition:
- Shared package id_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI), field bit positions, default widths.
- One natural sub-module: id_regfile_bypass, the parametrised register file with 2 read ports, 1 write port, reg0 hardwired and write-to-read bypass.

Test Plan:
- Reset then wb_en=1, wb_rd=3, wb_data=32'hDEAD_BEEF, instr with rs=3, if_valid=1 -> next edge idex_rs_data=32'hDEADBEEF, idex_valid=1.
- wb_rd=0, wb_data=32'h1234 -> later read of rs=0 gives 0.
- ex_valid=1, ex_mem_read=1, ex_rt=5, instr rt=5 -> stall_out=1; next cycle idex_valid=0. Drop ex_mem_read -> instruction loads the cycle after, idex_rt=5.
- flush=1 together with the hazard condition -> stall_out=0, idex_valid=0 next edge.
- ex_hold=1 for 3 cycles with a changing instr -> idex_* are unchanged and stall_out=1 throughout.
- instr=ori with imm 16'h8001 -> idex_imm=32'h0000_8001 with ID_ZEXT_EN, 32'hFFFF_8001 without; addi with the same imm gives 32'hFFFF_8001 in both builds.
